// File: rtl/uvme_st_arb_pkg.sv
// Shared types and helpers for the self-test stream round-robin arbiter.
//   uvme_st_arb_state_t : arbiter FSM state (IDLE, LOCKED)
//   grant_w()           : grant-index width for a given requester count
package uvme_st_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } uvme_st_arb_state_t;

    localparam int unsigned MIN_NUM_REQ = 2;
    localparam int unsigned MAX_NUM_REQ = 16;
    localparam int unsigned MAX_GNT_W   = $clog2(MAX_NUM_REQ);

    // Grant-index width; clamped to 1 so a degenerate count still yields a legal vector.
    function automatic int unsigned grant_w(input int unsigned num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/uvme_st_rr_picker.sv
// Combinational rotating-priority encoder.
//   i_req   : request vector, one bit per requester
//   i_ptr   : highest-priority index; search runs upward from here and wraps N-1 -> 0
//   o_found : at least one request set
//   o_index : first set request at or after i_ptr (0 when none)
module uvme_st_rr_picker
    import uvme_st_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W   = grant_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic               o_found,
    output logic [IDX_W-1:0]   o_index
);

    always_comb begin
        int w_best_dist;
        int w_dist;
        o_found     = |i_req;
        o_index     = '0;
        w_best_dist = int'(NUM_REQ);
        w_dist      = 0;
        // Distance of each slot from the pointer, modulo NUM_REQ; smallest requesting one wins.
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (i >= int'(i_ptr)) begin
                w_dist = i - int'(i_ptr);
            end else begin
                w_dist = i + int'(NUM_REQ) - int'(i_ptr);
            end
            if (i_req[i] && (w_dist < w_best_dist)) begin
                w_best_dist = w_dist;
                o_index     = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/uvme_st_rr_arb.sv
// Packet-locked round-robin arbiter sharing one transmit stream among NUM_REQ requesters.
// A grant is held from the first beat until the beat carrying last is accepted; the
// search pointer then moves past the winner so every requester gets a turn.
//   i_clk, i_reset        : clock, asynchronous active-high reset
//   i_req_valid/data/last : per-requester beat
//   o_req_ready           : per-requester accept, only the granted bit can be set
//   o_tx_valid/data/last  : output beat, i_tx_ready downstream accept
//   o_grant_id            : registered index of the granted requester
//   o_busy                : registered, high while a grant is held
module uvme_st_rr_arb
    import uvme_st_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ    = 4,
    parameter  int unsigned DATA_WIDTH = 32,
    localparam int unsigned GNT_W      = grant_w(NUM_REQ)
) (
    input  logic                                i_clk,
    input  logic                                i_reset,
    input  logic [NUM_REQ-1:0]                  i_req_valid,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  i_req_data,
    input  logic [NUM_REQ-1:0]                  i_req_last,
    output logic [NUM_REQ-1:0]                  o_req_ready,
    output logic                                o_tx_valid,
    output logic [DATA_WIDTH-1:0]               o_tx_data,
    output logic                                o_tx_last,
    input  logic                                i_tx_ready,
    output logic [GNT_W-1:0]                    o_grant_id,
    output logic                                o_busy
);

    uvme_st_arb_state_t r_state;
    uvme_st_arb_state_t w_state_next;
    logic [GNT_W-1:0]   r_grant_id;
    logic [GNT_W-1:0]   w_grant_next;
    logic [GNT_W-1:0]   r_ptr;
    logic [GNT_W-1:0]   w_ptr_next;
    logic               w_found;
    logic [GNT_W-1:0]   w_pick;

    uvme_st_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .i_req   (i_req_valid),
        .i_ptr   (r_ptr),
        .o_found (w_found),
        .o_index (w_pick)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= IDLE;
            r_grant_id <= '0;
            r_ptr      <= '0;
        end else begin
            r_state    <= w_state_next;
            r_grant_id <= w_grant_next;
            r_ptr      <= w_ptr_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_grant_next = r_grant_id;
        w_ptr_next   = r_ptr;
        o_tx_valid   = 1'b0;
        o_tx_data    = '0;
        o_tx_last    = 1'b0;
        o_req_ready  = '0;
        unique case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_next = LOCKED;
                    w_grant_next = w_pick;
                end
            end
            LOCKED: begin
                // Pure combinational pass-through; a stalled beat is simply re-presented.
                o_tx_valid              = i_req_valid[r_grant_id];
                o_tx_data               = i_req_data[r_grant_id];
                o_tx_last               = i_req_last[r_grant_id];
                o_req_ready[r_grant_id] = i_tx_ready;
                if (o_tx_valid && i_tx_ready && o_tx_last) begin
                    w_state_next = IDLE;
                    if (r_grant_id == GNT_W'(NUM_REQ - 1)) begin
                        w_ptr_next = '0;
                    end else begin
                        w_ptr_next = r_grant_id + GNT_W'(1);
                    end
                end
            end
        endcase
    end

    assign o_grant_id = r_grant_id;
    assign o_busy     = (r_state == LOCKED);

endmodule

// File: tb/tb_uvme_st_rr_arb.sv
module tb_uvme_st_rr_arb;

    localparam int NR = 4;
    localparam int DW = 32;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic [NR-1:0]          req_valid;
    logic [NR-1:0][DW-1:0]  req_data;
    logic [NR-1:0]          req_last;
    logic [NR-1:0]          req_ready;
    logic                   tx_valid;
    logic [DW-1:0]          tx_data;
    logic                   tx_last;
    logic                   tx_ready;
    logic [1:0]             grant_id;
    logic                   busy;

    int checks = 0;
    int errors = 0;

    // Source model: each requester sends npkts packets of pkt_len beats.
    int          pkt_len [NR];
    int          npkts   [NR];
    int          pkt_no  [NR];
    int          beat    [NR];
    logic [NR-1:0] hold;

    always #5 clk = ~clk;

    uvme_st_rr_arb #(
        .NUM_REQ    (NR),
        .DATA_WIDTH (DW)
    ) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_req_valid (req_valid),
        .i_req_data  (req_data),
        .i_req_last  (req_last),
        .o_req_ready (req_ready),
        .o_tx_valid  (tx_valid),
        .o_tx_data   (tx_data),
        .o_tx_last   (tx_last),
        .i_tx_ready  (tx_ready),
        .o_grant_id  (grant_id),
        .o_busy      (busy)
    );

    // Beat payload: 0x1000*(req+1) + 16*packet + beat
    function automatic logic [31:0] dval(input int i, input int p, input int b);
        return 32'(32'h1000 * (i + 1) + 16 * p + b);
    endfunction

    task automatic clear_src();
        for (int i = 0; i < NR; i++) begin
            pkt_len[i] = 1;
            npkts[i]   = 0;
            pkt_no[i]  = 0;
            beat[i]    = 0;
        end
        hold = '0;
    endtask

    task automatic drive_src();
        for (int i = 0; i < NR; i++) begin
            req_valid[i] = (npkts[i] > 0) && !hold[i];
            req_data[i]  = dval(i, pkt_no[i], beat[i]);
            req_last[i]  = req_valid[i] && (beat[i] == pkt_len[i] - 1);
        end
    endtask

    task automatic advance_src();
        for (int i = 0; i < NR; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                if (req_last[i]) begin
                    beat[i]   = 0;
                    pkt_no[i] = pkt_no[i] + 1;
                    npkts[i]  = npkts[i] - 1;
                end else begin
                    beat[i] = beat[i] + 1;
                end
            end
        end
    endtask

    task automatic apply_reset();
        reset    = 1'b1;
        tx_ready = 1'b1;
        clear_src();
        drive_src();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        tx_ready = 1'b1;
        clear_src();
        npkts[1] = 1;
        npkts[3] = 1;
        drive_src();
        @(negedge clk);
        #1;
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rst_tx_valid got %0b want 0", tx_valid); end
        checks++; if (tx_last !== 1'b0) begin errors++; $display("FAIL rst_tx_last got %0b want 0", tx_last); end
        checks++; if (tx_data !== '0) begin errors++; $display("FAIL rst_tx_data got %h want 0", tx_data); end
        checks++; if (req_ready !== '0) begin errors++; $display("FAIL rst_req_ready got %b want 0", req_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b want 0", busy); end
        checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL rst_grant got %0d want 0", grant_id); end
        reset = 1'b0;
        @(negedge clk);
        drive_src();
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL first_grant_busy got %0b want 1", busy); end
        checks++; if (grant_id !== 2'd1) begin errors++; $display("FAIL first_grant_id got %0d want 1", grant_id); end
        checks++; if (tx_data !== 32'h2000) begin errors++; $display("FAIL first_grant_data got %h want 2000", tx_data); end
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL first_grant_ready got %b want 0010", req_ready); end
        advance_src();
        @(negedge clk);
        drive_src();
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL first_grant_release got %0b want 0", busy); end
    endtask

    task automatic test_two_packets();
        int          e_b [9] = '{0, 1, 1, 1, 0, 1, 1, 1, 0};
        int          e_g [9] = '{0, 0, 0, 0, 0, 2, 2, 2, 2};
        int          e_l [9] = '{0, 0, 0, 1, 0, 0, 0, 1, 0};
        logic [31:0] e_d [9] = '{32'h0, 32'h1000, 32'h1001, 32'h1002, 32'h0,
                                 32'h3000, 32'h3001, 32'h3002, 32'h0};
        apply_reset();
        pkt_len[0] = 3; npkts[0] = 1;
        pkt_len[2] = 3; npkts[2] = 1;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            drive_src();
            #1;
            checks++; if (busy !== e_b[c][0]) begin errors++; $display("FAIL two_pkt c%0d busy got %0b want %0d", c, busy, e_b[c]); end
            checks++; if (grant_id !== e_g[c][1:0]) begin errors++; $display("FAIL two_pkt c%0d grant got %0d want %0d", c, grant_id, e_g[c]); end
            checks++; if (tx_valid !== e_b[c][0]) begin errors++; $display("FAIL two_pkt c%0d tx_valid got %0b want %0d", c, tx_valid, e_b[c]); end
            checks++; if (tx_data !== e_d[c]) begin errors++; $display("FAIL two_pkt c%0d tx_data got %h want %h", c, tx_data, e_d[c]); end
            checks++; if (tx_last !== e_l[c][0]) begin errors++; $display("FAIL two_pkt c%0d tx_last got %0b want %0d", c, tx_last, e_l[c]); end
            advance_src();
        end
    endtask

    task automatic test_all_four();
        int          e_b [13] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0};
        int          e_g [13] = '{0, 0, 0, 1, 1, 2, 2, 3, 3, 0, 0, 1, 1};
        logic [31:0] e_d [13] = '{32'h0, 32'h1000, 32'h0, 32'h2000, 32'h0, 32'h3000, 32'h0,
                                  32'h4000, 32'h0, 32'h1010, 32'h0, 32'h2010, 32'h0};
        apply_reset();
        for (int i = 0; i < NR; i++) npkts[i] = 4;
        for (int c = 0; c < 13; c++) begin
            @(negedge clk);
            drive_src();
            #1;
            checks++; if (busy !== e_b[c][0]) begin errors++; $display("FAIL all4 c%0d busy got %0b want %0d", c, busy, e_b[c]); end
            checks++; if (grant_id !== e_g[c][1:0]) begin errors++; $display("FAIL all4 c%0d grant got %0d want %0d", c, grant_id, e_g[c]); end
            checks++; if (tx_valid !== e_b[c][0]) begin errors++; $display("FAIL all4 c%0d tx_valid got %0b want %0d", c, tx_valid, e_b[c]); end
            checks++; if (tx_data !== e_d[c]) begin errors++; $display("FAIL all4 c%0d tx_data got %h want %h", c, tx_data, e_d[c]); end
            advance_src();
        end
    endtask

    task automatic test_stall();
        int          e_r [7] = '{1, 1, 0, 0, 1, 1, 1};
        int          e_b [7] = '{0, 1, 1, 1, 1, 1, 0};
        int          e_l [7] = '{0, 0, 0, 0, 0, 1, 0};
        logic [3:0]  e_q [7] = '{4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0000};
        logic [31:0] e_d [7] = '{32'h0, 32'h2000, 32'h2001, 32'h2001, 32'h2001, 32'h2002, 32'h0};
        apply_reset();
        pkt_len[1] = 3; npkts[1] = 1;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            tx_ready = e_r[c][0];
            drive_src();
            #1;
            checks++; if (busy !== e_b[c][0]) begin errors++; $display("FAIL stall c%0d busy got %0b want %0d", c, busy, e_b[c]); end
            checks++; if (tx_valid !== e_b[c][0]) begin errors++; $display("FAIL stall c%0d tx_valid got %0b want %0d", c, tx_valid, e_b[c]); end
            checks++; if (tx_data !== e_d[c]) begin errors++; $display("FAIL stall c%0d tx_data got %h want %h", c, tx_data, e_d[c]); end
            checks++; if (tx_last !== e_l[c][0]) begin errors++; $display("FAIL stall c%0d tx_last got %0b want %0d", c, tx_last, e_l[c]); end
            checks++; if (req_ready !== e_q[c]) begin errors++; $display("FAIL stall c%0d req_ready got %b want %b", c, req_ready, e_q[c]); end
            advance_src();
        end
        tx_ready = 1'b1;
    endtask

    task automatic test_drop();
        int          e_h [11] = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0};
        int          e_b [11] = '{0, 1, 1, 1, 1, 1, 1, 1, 0, 1, 0};
        int          e_g [11] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 3, 3};
        int          e_v [11] = '{0, 1, 1, 0, 0, 0, 1, 1, 0, 1, 0};
        logic [3:0]  e_q [11] = '{4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010,
                                  4'b0010, 4'b0010, 4'b0000, 4'b1000, 4'b0000};
        logic [31:0] e_d [11] = '{32'h0, 32'h2000, 32'h2001, 32'h0, 32'h0, 32'h0,
                                  32'h2002, 32'h2003, 32'h0, 32'h4000, 32'h0};
        apply_reset();
        pkt_len[1] = 4; npkts[1] = 1;
        pkt_len[3] = 1; npkts[3] = 1;
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            hold[1] = e_h[c][0];
            drive_src();
            #1;
            checks++; if (busy !== e_b[c][0]) begin errors++; $display("FAIL drop c%0d busy got %0b want %0d", c, busy, e_b[c]); end
            checks++; if (grant_id !== e_g[c][1:0]) begin errors++; $display("FAIL drop c%0d grant got %0d want %0d", c, grant_id, e_g[c]); end
            checks++; if (tx_valid !== e_v[c][0]) begin errors++; $display("FAIL drop c%0d tx_valid got %0b want %0d", c, tx_valid, e_v[c]); end
            checks++; if (req_ready !== e_q[c]) begin errors++; $display("FAIL drop c%0d req_ready got %b want %b", c, req_ready, e_q[c]); end
            if (e_v[c] != 0) begin
                checks++; if (tx_data !== e_d[c]) begin errors++; $display("FAIL drop c%0d tx_data got %h want %h", c, tx_data, e_d[c]); end
            end
            advance_src();
        end
    endtask

    task automatic test_reset_mid();
        int          e_b [5] = '{0, 1, 0, 1, 1};
        int          e_g [5] = '{0, 0, 0, 2, 2};
        logic [31:0] e_d [5] = '{32'h0, 32'h1000, 32'h0, 32'h3000, 32'h3001};
        apply_reset();
        pkt_len[0] = 1; npkts[0] = 1;
        pkt_len[2] = 4; npkts[2] = 1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            drive_src();
            #1;
            checks++; if (busy !== e_b[c][0]) begin errors++; $display("FAIL rmid c%0d busy got %0b want %0d", c, busy, e_b[c]); end
            checks++; if (grant_id !== e_g[c][1:0]) begin errors++; $display("FAIL rmid c%0d grant got %0d want %0d", c, grant_id, e_g[c]); end
            checks++; if (tx_data !== e_d[c]) begin errors++; $display("FAIL rmid c%0d tx_data got %h want %h", c, tx_data, e_d[c]); end
            if (c < 4) advance_src();
        end
        // Second beat of requester 2 is on the bus; reset lands before the clock edge.
        reset = 1'b1;
        #1;
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rmid_async tx_valid got %0b want 0", tx_valid); end
        checks++; if (tx_last !== 1'b0) begin errors++; $display("FAIL rmid_async tx_last got %0b want 0", tx_last); end
        checks++; if (tx_data !== '0) begin errors++; $display("FAIL rmid_async tx_data got %h want 0", tx_data); end
        checks++; if (req_ready !== '0) begin errors++; $display("FAIL rmid_async req_ready got %b want 0", req_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_async busy got %0b want 0", busy); end
        checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL rmid_async grant got %0d want 0", grant_id); end
        @(posedge clk);
        clear_src();
        npkts[0] = 1;
        npkts[2] = 1;
        @(negedge clk);
        reset = 1'b0;
        drive_src();
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_release busy got %0b want 0", busy); end
        advance_src();
        @(negedge clk);
        drive_src();
        #1;
        checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL rmid_regrant grant got %0d want 0", grant_id); end
        checks++; if (tx_data !== 32'h1000) begin errors++; $display("FAIL rmid_regrant tx_data got %h want 1000", tx_data); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_regrant busy got %0b want 1", busy); end
        advance_src();
    endtask

    initial begin
        tx_ready  = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        hold      = '0;
        test_reset();
        test_two_packets();
        test_all_four();
        test_stall();
        test_drop();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uvme_st_rr_arb.md
# uvme_st_rr_arb

Packet-locked round-robin arbiter that shares the self-test environment's single transmit stream among `NUM_REQ` requesters. It sits between the stimulus sources and the transmit side of the `uvma_if` pair monitored by the self-test checker. It grants one requester at a time and holds that grant until the packet's last beat completes. Grant position then rotates, so no requester starves.

## Interface
- `NUM_REQ`, default 4: number of requesters; legal range 2..16.
- `DATA_WIDTH`, default 32: beat data width in bits.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `req_valid` in NUM_REQ: per-requester beat valid.
- `req_data` in NUM_REQ×DATA_WIDTH: per-requester beat data.
- `req_last` in NUM_REQ: per-requester end-of-packet flag, qualified by valid.
- `req_ready` out NUM_REQ: per-requester beat accept; at most one bit set.
- `tx_valid` out 1: output beat valid.
- `tx_data` out DATA_WIDTH: output beat data.
- `tx_last` out 1: output end-of-packet.
- `tx_ready` in 1: downstream accept.
- `grant_id` out $clog2(NUM_REQ): index of the currently granted requester.
- `busy` out 1: high while a grant is held (LOCKED).

## Operation
- Two-state FSM, IDLE and LOCKED. Registered state: `state`, `grant_id`, and rotating pointer `ptr`.
- IDLE:
  - If any `req_valid` is set, pick the first set bit searching from `ptr` upward and wrapping N-1→0.
  - Load that index into `grant_id` and move to LOCKED.
  - Otherwise stay in IDLE.
- LOCKED (g = `grant_id`):
  - `tx_valid` = `req_valid[g]`, `tx_data` = `req_data[g]`, `tx_last` = `req_last[g]`.
  - `req_ready[g]` = `tx_ready`; every other `req_ready` bit is 0.
- Packet end: a beat with `tx_valid & tx_ready & tx_last` moves the FSM to IDLE and sets `ptr` to g+1 modulo NUM_REQ.
- In IDLE: `tx_valid`=0, `tx_last`=0, `tx_data`=0, `req_ready`=0.
- Beat handshake: a beat transfers only when valid and ready are both high in the same cycle. While `tx_ready` is low, the arbiter never drops or reorders a beat.
- Boundary cases:
  - Granted requester deasserts `req_valid` mid-packet: the grant is held, `tx_valid` goes low, and nothing switches until that requester's last beat. There is no timeout.
  - Other requesters raise valid during LOCKED: they wait. Their ready stays 0.
  - Single-beat packet (first beat has last=1): LOCKED lasts exactly as many cycles as `tx_ready` takes to accept that beat.
  - Only one requester active: it is re-granted every packet. Rotation skips the empty slots.
  - Pointer wrap: after g=NUM_REQ-1, `ptr`=0.
- Reset, including mid-packet:
  - Immediately on assertion: state=IDLE, `ptr`=0, `grant_id`=0, `busy`=0.
  - All outputs read 0 until the first grant after release.
  - A partially sent packet is abandoned; the block does not resume it.

## Timing
- Arbitration latency: `req_valid` seen in IDLE at cycle N → LOCKED and `grant_id` valid at cycle N+1 → first `tx_valid` at cycle N+1.
- Data path in LOCKED is combinational, zero latency: requester→tx and `tx_ready`→`req_ready`.
- Exactly one IDLE cycle between consecutive packets. Peak throughput for P-beat packets is P/(P+1).
- `busy` and `grant_id` are registered. `busy` = (state==LOCKED).

## Structure
- Shared package `uvme_st_arb_pkg`:
  - state enum `uvme_st_arb_state_t` {IDLE, LOCKED}.
  - localparams for the grant-index width.
- Sub-module `uvme_st_rr_picker`:
  - Combinational rotating-priority encoder.
  - Inputs: request vector and `ptr`. Outputs: `found` and `index`.
- Top module holds the FSM, registers and output muxing.

## Test plan
- Reset → `tx_valid`, `tx_last`, `tx_data`, `req_ready`, `busy` and `grant_id` all 0. First grant after release goes to the lowest valid index.
- Requesters 0 and 2 raise valid in the same cycle with 3-beat packets (A0–A2, C0–C2), `tx_ready`=1 → tx shows A0,A1,A2, one idle cycle, then C0,C1,C2; `grant_id` sequence 0 then 2.
- All 4 requesters continuously valid with single-beat packets → grant order 0,1,2,3,0,1; each beat followed by one idle cycle.
- `tx_ready` low for 2 cycles mid-packet → `tx_data` held stable, `req_ready[g]`=0 during the stall, no beat lost or duplicated.
- Granted requester 1 drops valid for 3 cycles mid-packet while requester 3 is valid → `tx_valid`=0 for those cycles, `grant_id` stays 1, requester 3 is granted only after 1's last beat.
- Reset asserted on beat 2 of a 4-beat packet from requester 2 → outputs 0 in the same cycle, `ptr`=0; after release with requesters 0 and 2 valid, requester 0 wins.
